// File: rtl/alu_iter.sv
// Iterative integer ALU: single-cycle logic/arith/shift ops plus XLEN-cycle
// shift-add multiply and restoring divide, with a valid/ready handshake on both sides.
module alu_iter #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(XLEN);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  state_t          r_state, w_state_nxt;
  logic            w_accept;
  logic [SHW:0]    r_cnt;
  logic            r_mul, r_rem;
  logic [XLEN-1:0] r_a, r_b, r_acc, r_out;

  logic            w_iter;
  logic [SHW-1:0]  w_sh;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt;

  assign w_iter = (op == 5'b11000) || (op == 5'b11100) || (op == 5'b11101);
  assign w_sh   = op2[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (op)
      5'b01100, 5'b01101: w_alu = op1 + op2;
      5'b01110:           w_alu = op1 - op2;
      5'b01000:           w_alu = op1 << w_sh;
      5'b01001:           w_alu = op1 >> w_sh;
      5'b01010:           w_alu = $signed(op1) >>> w_sh;
      5'b00110:           w_alu = op1 ^ op2;
      5'b00101:           w_alu = op1 | op2;
      5'b00100:           w_alu = op1 & op2;
      5'b00010:           w_alu = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      5'b00011:           w_alu = {{(XLEN-1){1'b0}}, (op1 < op2)};
      default:            w_alu = '0;
    endcase
  end

  // Multiply: r_a shifts left as the multiplicand, r_b right as the multiplier.
  assign w_mul_nxt = r_acc + (r_b[0] ? r_a : '0);

  // Divide: r_a shifts the dividend out of its MSB and collects quotient bits in its LSB;
  // the remainder stays below the divisor, so one extra bit is enough for the trial subtract.
  assign w_rem_sh  = {r_acc, r_a[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_qbit    = ~w_diff[XLEN];
  assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt = {r_a[XLEN-2:0], w_qbit};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_iter ? CALC : DONE;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == CNT_ONE) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = w_iter ? CALC : DONE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_mul <= 1'b0;
      r_rem <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_out <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_INIT;
      r_mul <= (op == 5'b11000);
      r_rem <= (op == 5'b11101);
      if (w_iter) begin
        r_a   <= op1;
        r_b   <= op2;
        r_acc <= '0;
      end else begin
        r_out <= w_alu;
      end
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt - CNT_ONE;
      if (r_mul) begin
        r_acc <= w_mul_nxt;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
      end else begin
        r_acc <= w_rem_nxt;
        r_a   <= w_quo_nxt;
      end
      if (r_cnt == CNT_ONE)
        r_out <= r_mul ? w_mul_nxt : (r_rem ? w_rem_nxt : w_quo_nxt);
    end
  end

  assign alu_out = r_out;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, handshake/reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_iter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      op = '0;
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] alu_out;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] last_res = '0;

  always #5 clk = ~clk;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .busy(busy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int unsigned sh;
    sh = b % 32;
    p  = {32'b0, a} * {32'b0, b};
    case (o)
      5'b01100, 5'b01101: return a + b;
      5'b01110: return a - b;
      5'b01000: return a << sh;
      5'b01001: return a >> sh;
      5'b01010: return $signed(a) >>> sh;
      5'b00110: return a ^ b;
      5'b00101: return a | b;
      5'b00100: return a & b;
      5'b00010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b00011: return (a < b) ? 32'd1 : 32'd0;
      5'b11000: return p[31:0];
      5'b11100: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'b11101: return (b == 0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] o);
    return (o == 5'b11000 || o == 5'b11100 || o == 5'b11101) ? XLEN + 1 : 1;
  endfunction

  // Called at a negedge with the DUT idle. Garbage with in_valid high is held
  // on the inputs while waiting, which the DUT must ignore.
  task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int nbusy, output int bad);
    in_valid = 1'b1; op = o; op1 = a; op2 = b;
    lat = 0; nbusy = 0; bad = 0;
    @(posedge clk);
    @(negedge clk);
    op = 5'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (busy) nbusy++;
      if (in_ready) bad++;
      if (alu_out !== last_res) bad++;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    res = alu_out;
    last_res = alu_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t vt[19];
  logic [4:0] codes[14];

  initial begin
    logic [31:0] res;
    int lat, nbusy, bad, stale;
    logic [4:0] o;
    logic [31:0] a, b;

    vt[0]  = '{5'b01100, 32'd5, 32'd7, 32'd12, 1};
    vt[1]  = '{5'b01101, 32'd5, 32'd7, 32'd12, 1};
    vt[2]  = '{5'b01110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1};
    vt[3]  = '{5'b01010, 32'h8000_0000, 32'h24, 32'hF800_0000, 1};
    vt[4]  = '{5'b01001, 32'h8000_0000, 32'h24, 32'h0800_0000, 1};
    vt[5]  = '{5'b01000, 32'd1, 32'h21, 32'd2, 1};
    vt[6]  = '{5'b00010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1};
    vt[7]  = '{5'b00011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1};
    vt[8]  = '{5'b00110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1};
    vt[9]  = '{5'b00101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1};
    vt[10] = '{5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1};
    vt[11] = '{5'b10000, 32'd5, 32'd7, 32'd0, 1};
    vt[12] = '{5'b10101, 32'd5, 32'd7, 32'd0, 1};
    vt[13] = '{5'b11000, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 33};
    vt[14] = '{5'b11100, 32'd100, 32'd7, 32'd14, 33};
    vt[15] = '{5'b11101, 32'd100, 32'd7, 32'd2, 33};
    vt[16] = '{5'b11100, 32'd9, 32'd0, 32'hFFFF_FFFF, 33};
    vt[17] = '{5'b11101, 32'd9, 32'd0, 32'd9, 33};
    vt[18] = '{5'b11000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33};

    codes = '{5'b01100, 5'b01101, 5'b01110, 5'b01000, 5'b01001, 5'b01010, 5'b00110,
              5'b00101, 5'b00100, 5'b00010, 5'b00011, 5'b11000, 5'b11100, 5'b11101};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // directed table; first op is accepted on the first edge after release
    for (int i = 0; i < 19; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, res, lat, nbusy, bad);
      chk($sformatf("vec%0d_res", i), res, vt[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy", i), nbusy, vt[i].lat - 1);
      chk($sformatf("vec%0d_hold", i), bad, 0);
    end

    // result stall with out_ready low, then back-to-back accept from DONE
    in_valid = 1'b1; op = 5'b01100; op1 = 32'd5; op2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    op = 5'b01110; op1 = 32'd100; op2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_out", alu_out, 32'd12);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    op = 5'b01100; op1 = 32'd1; op2 = 32'd1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_out", alu_out, 32'd2);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle_ready", {31'b0, in_ready}, 32'd1);
    chk("b2b_idle_valid", {31'b0, out_valid}, 32'd0);
    last_res = 32'd2;

    // reset in the middle of a divide
    in_valid = 1'b1; op = 5'b11100; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_out", alu_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid || busy || !in_ready) stale++;
      @(negedge clk);
    end
    chk("mrst_no_stale", stale, 0);
    last_res = 32'd0;

    // randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      o = ($urandom_range(0, 3) == 0) ? 5'($urandom) : codes[$urandom_range(0, 13)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      do_op(o, a, b, res, lat, nbusy, bad);
      chk($sformatf("rnd%0d_op%05b_res", i, o), res, ref_alu(o, a, b));
      chk($sformatf("rnd%0d_op%05b_lat", i, o), lat, ref_lat(o));
      chk($sformatf("rnd%0d_hold", i), bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width (power of two, >= 8).
REQ-002 The block SHALL have parameter SHW, default $clog2(XLEN), shift-amount width (derived, not overridden).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  5  operation code, sampled on accept.
REQ-008 op1  input  XLEN  first operand, sampled on accept.
REQ-009 op2  input  XLEN  second operand, sampled on accept.
REQ-010 out_valid  output  1  alu_out holds a completed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 alu_out  output  XLEN  registered result.
REQ-013 busy  output  1  high while an iterative operation is computing.

Function
REQ-014 Accept SHALL occur on a rising edge where in_valid && in_ready; op/op1/op2 SHALL be captured internally and never re-sampled.
REQ-015 FSM states SHALL be IDLE, CALC, DONE; in_ready = (IDLE) || (DONE && out_ready); out_valid = (DONE); busy = (CALC).
REQ-016 Single-cycle ops: 01100/01101 add, 01110 sub, 01000 sll, 01001 srl, 01010 sra, 00110 xor, 00101 or, 00100 and, 00010 slt (signed, result 0/1), 00011 sltu (unsigned, result 0/1).
REQ-017 Shifts SHALL use op2[SHW-1:0] only; sra SHALL replicate op1[XLEN-1].
REQ-018 Add/sub/mul SHALL wrap modulo 2^XLEN; no carry/overflow output.
REQ-019 Codes 10000, 10001, 10100, 10101 and all undefined codes SHALL be single-cycle with result 0.
REQ-020 Iterative ops: 11000 mul (low XLEN bits of unsigned product, shift-add), 11100 divu (quotient), 11101 remu (remainder), restoring division, one bit per cycle.
REQ-021 Single-cycle op accepted at edge T: SHALL transition to DONE with alu_out valid after edge T (out_valid high in cycle T+1).
REQ-022 Iterative op accepted at edge T: SHALL enter CALC for exactly XLEN cycles, then DONE; out_valid SHALL first be high XLEN+1 cycles after T.
REQ-023 Iteration counter SHALL be SHW+1 bits, loaded with XLEN on accept, decremented each CALC cycle, CALC->DONE when it reaches 1 and decrements.
REQ-024 divu with op2 = 0 SHALL return all ones; remu with op2 = 0 SHALL return op1; both SHALL still take XLEN+1 cycles.
REQ-025 In DONE, alu_out and out_valid SHALL hold stable until out_ready; DONE && out_ready && !in_valid -> IDLE.
REQ-026 DONE && out_ready && in_valid SHALL accept the new request in the same edge (back-to-back, no idle bubble).
REQ-027 in_valid during CALC or DONE-without-out_ready SHALL be ignored (in_ready low; requester must hold).
REQ-028 alu_out SHALL change only on entry to DONE; CALC cycles SHALL NOT disturb the previous alu_out value.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, out_valid 0, busy 0, alu_out 0, counter 0, internal operand/accumulator registers 0.
REQ-030 Reset during CALC or DONE SHALL discard the operation; no result SHALL be produced after release.
REQ-031 First accept SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-032 add op1=5, op2=7 accepted at T -> out_valid in cycle T+1, alu_out=12; sub 5-7 -> 0xFFFFFFFE.
REQ-033 sra 0x80000000, op2=0x24 -> 0xF8000000 (shift 4); srl same -> 0x08000000; slt 0xFFFFFFFF,1 -> 1; sltu -> 0.
REQ-034 mul 0x00010000 x 0x00010001 at T -> busy cycles T+1..T+32, in_ready low, out_valid at T+33, alu_out=0x00010000.
REQ-035 divu 100/7 -> 14, remu 100/7 -> 2; divu 9/0 -> 0xFFFFFFFF; remu 9/0 -> 9; each 33 cycles.
REQ-036 Result with out_ready low 5 cycles -> alu_out/out_valid stable, in_ready low; then out_ready=1 with in_valid add 1+1 -> next result 2 one cycle later.
REQ-037 rst_n low at cycle 10 of divu -> out_valid/busy 0 immediately, alu_out 0; after release in_ready=1, no stale result.
